// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream blocks: width helpers and the arbiter
// state encoding.
package axis_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // An index field is never narrower than one bit, even for a single port.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: an output register plus one skid entry. Upstream
// ready is a flop, so there is no combinational path from i_ready to o_ready.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  // Handshake: a beat moves on a port in the cycle where its valid and ready
  // are both high at the rising edge; valid never waits on ready.
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_in_ready;
  logic             w_in_fire;
  logic             w_out_free;

  always_comb begin
    w_in_fire  = i_valid & r_in_ready;
    w_out_free = ~r_out_valid | i_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b1;
    end else if (w_out_free) begin
      // Skid entry always drains first so ordering is preserved.
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) r_out_data <= i_data;
      end
      r_in_ready <= 1'b1;
    end else if (w_in_fire) begin
      r_skid_data  <= i_data;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/axis_join_rr.sv
// N-to-1 AXI-Stream join with packet-atomic round-robin arbitration; every
// output beat carries the index of its source port on m_tid.
module axis_join_rr
  import axis_pkg::*;
#(
  parameter  int AXIS_DATA_WIDTH = 32,
  parameter  int NUM_PORTS       = 4,
  localparam int ID_WIDTH        = id_width(NUM_PORTS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   s_tvalid,
  output logic [NUM_PORTS-1:0]                   s_tready,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH/8-1:0] s_tstrb,
  input  logic [NUM_PORTS-1:0]                   s_tlast,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic [AXIS_DATA_WIDTH-1:0]             m_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]           m_tstrb,
  output logic                                   m_tlast,
  output logic [ID_WIDTH-1:0]                    m_tid
);

  localparam int W  = AXIS_DATA_WIDTH;
  localparam int SW = W / 8;
  localparam int PW = W + SW + 1 + ID_WIDTH;

  arb_state_e          r_state;
  logic [ID_WIDTH-1:0] r_grant;
  logic [ID_WIDTH-1:0] r_rr_ptr;

  logic                w_any;
  logic [ID_WIDTH-1:0] w_sel;
  logic [ID_WIDTH-1:0] w_next_ptr;
  logic                w_g_valid;
  logic                w_g_last;
  logic [W-1:0]        w_g_data;
  logic [SW-1:0]       w_g_strb;
  logic                w_push;
  logic                w_fire;
  logic                w_buf_ready;
  logic [PW-1:0]       w_buf_in;
  logic [PW-1:0]       w_buf_out;

  // First valid port at or after r_rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_PORTS;
      if (!w_any && s_tvalid[idx]) begin
        w_any = 1'b1;
        w_sel = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    w_g_valid  = s_tvalid[r_grant];
    w_g_last   = s_tlast[r_grant];
    w_g_data   = s_tdata[int'(r_grant)*W +: W];
    w_g_strb   = s_tstrb[int'(r_grant)*SW +: SW];
    w_push     = (r_state == ST_LOCKED) & w_g_valid;
    w_fire     = w_push & w_buf_ready;
    w_next_ptr = (int'(r_grant) == NUM_PORTS - 1) ? '0 : r_grant + ID_WIDTH'(1);
    w_buf_in   = {w_g_data, w_g_strb, w_g_last, r_grant};
  end

  always_comb begin
    s_tready = '0;
    if (r_state == ST_LOCKED) s_tready[r_grant] = w_buf_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_sel;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // The lock holds through gaps in the granted port's valid.
          if (w_fire && w_g_last) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  axis_skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_push),
    .o_ready(w_buf_ready),
    .i_data (w_buf_in),
    .o_valid(m_tvalid),
    .i_ready(m_tready),
    .o_data (w_buf_out)
  );

  assign {m_tdata, m_tstrb, m_tlast, m_tid} = w_buf_out;

endmodule

// File: tb/tb_axis_join_rr.sv
// Directed bench for axis_join_rr: per-port source queues feed the DUT, accepted
// beats go to an expected queue, and the output monitor pops and compares them.
module tb_axis_join_rr;

  localparam int W  = 32;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP-1:0]   s_tvalid = '0;
  logic [NP-1:0]   s_tready;
  logic [NP*W-1:0] s_tdata = '0;
  logic [NP*4-1:0] s_tstrb = '0;
  logic [NP-1:0]   s_tlast = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [W-1:0]    m_tdata;
  logic [3:0]      m_tstrb;
  logic            m_tlast;
  logic [1:0]      m_tid;

  axis_join_rr #(
    .AXIS_DATA_WIDTH(W),
    .NUM_PORTS      (NP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata (s_tdata),
    .s_tstrb (s_tstrb),
    .s_tlast (s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata (m_tdata),
    .m_tstrb (m_tstrb),
    .m_tlast (m_tlast),
    .m_tid   (m_tid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [36:0] src_q [NP][$];   // {last, strb, data}
  logic [38:0] exp_q[$];        // {tid, last, strb, data}
  int          acc_q[$];
  logic [1:0]  out_tid_q[$];
  int          out_cyc_q[$];
  int          lat_q[$];
  logic [NP-1:0] pause = '0;
  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      logic [36:0] b;
      if (src_q[p].size() > 0 && !pause[p]) begin
        b = src_q[p][0];
        s_tvalid[p]         = 1'b1;
        s_tdata[p*W +: W]   = b[31:0];
        s_tstrb[p*4 +: 4]   = b[35:32];
        s_tlast[p]          = b[36];
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
      end
    end
  end

  // ---------------- acceptance + output monitor ----------------
  logic        prev_stall = 1'b0;
  logic [38:0] prev_pay   = '0;

  always @(negedge clk) begin
    logic [38:0] pay;
    logic [38:0] e;
    logic [36:0] b;
    int a;
    pay = {m_tid, m_tlast, m_tstrb, m_tdata};
    if (!rst) begin
      if (prev_stall) check("stall_stable", pay, prev_pay);
      if (m_tvalid && m_tready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("beat", pay, e);
          out_tid_q.push_back(m_tid);
          out_cyc_q.push_back(cyc);
          lat_q.push_back(cyc - a);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_pay   = pay;
      for (int p = 0; p < NP; p++) begin
        if (s_tvalid[p] && s_tready[p]) begin
          b = src_q[p].pop_front();
          exp_q.push_back({2'(p), b});
          acc_q.push_back(cyc);
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- helper tasks ----------------
  task automatic push_pkt(input int p, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      d = base + 32'(i);
      src_q[p].push_back({(i == n - 1), d[3:0], d});
    end
  endtask

  task automatic clear_logs();
    out_tid_q.delete();
    out_cyc_q.delete();
    lat_q.delete();
  endtask

  // Called just after a rising edge; asserts rst for two edges.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    pause = '0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    @(posedge clk);
    #2;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tstrb", m_tstrb, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tid", m_tid, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    clear_logs();
  endtask

  task automatic wait_drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #2;
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
          src_q[3].size() == 0 && exp_q.size() == 0 && !m_tvalid)
        done = 1'b1;
    end
    check(tag, done, 1);
  endtask

  task automatic check_tids(input string tag, input int n, input logic [1:0] exp [10]);
    check({tag, "_count"}, out_tid_q.size(), n);
    for (int i = 0; i < n && i < out_tid_q.size(); i++) check(tag, out_tid_q[i], exp[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] tids [10];
    logic [5:0] pat;
    logic       ok;

    @(posedge clk);
    do_reset();

    // Single 4-beat packet on port 2.
    push_pkt(2, 4, 32'hA0);
    wait_drain("t1_drain");
    tids = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    check_tids("t1_tid", 4, tids);
    for (int i = 0; i < lat_q.size(); i++) check("t1_latency", lat_q[i], 1);
    for (int i = 1; i < out_cyc_q.size(); i++)
      check("t1_back_to_back", out_cyc_q[i] - out_cyc_q[i-1], 1);

    // Port 3 alone, then ports 0 and 3 together: wrap gives port 0.
    clear_logs();
    push_pkt(3, 2, 32'h30);
    wait_drain("t3a_drain");
    push_pkt(0, 2, 32'h00);
    push_pkt(3, 2, 32'h38);
    wait_drain("t3b_drain");
    tids = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    check_tids("t3_tid", 6, tids);

    // Port 1 pauses mid-packet while port 3 waits.
    clear_logs();
    push_pkt(1, 4, 32'h10);
    push_pkt(3, 2, 32'h3C);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      if (src_q[1].size() == 2) ok = 1'b1;
    end
    check("t4_reach_mid", ok, 1);
    pause[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_port3_blocked", s_tready[3], 0);
    end
    check("t4_lock_held", s_tready[1], 1);
    pause[1] = 1'b0;
    wait_drain("t4_drain");
    tids = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    check_tids("t4_tid", 6, tids);

    // m_tready pattern over a 16-beat packet; strobes include all-zero.
    clear_logs();
    pat = 6'b101001;
    push_pkt(0, 16, 32'h0);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk);
      #1;
      m_tready = pat[k % 6];
      if (src_q[0].size() == 0 && exp_q.size() == 0 && !m_tvalid) ok = 1'b1;
    end
    m_tready = 1'b1;
    check("t5_drain", ok, 1);
    check("t5_count", out_tid_q.size(), 16);

    // All ports valid with 2-beat packets after a fresh reset.
    @(posedge clk);
    do_reset();
    push_pkt(0, 2, 32'h100);
    push_pkt(1, 2, 32'h110);
    push_pkt(2, 2, 32'h120);
    push_pkt(3, 2, 32'h130);
    push_pkt(0, 2, 32'h140);
    wait_drain("t2_drain");
    tids = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    check_tids("t2_tid", 10, tids);
    for (int i = 1; i < out_cyc_q.size(); i++)
      check("t2_gap", out_cyc_q[i] - out_cyc_q[i-1], (i % 2 == 1) ? 1 : 2);

    // Reset mid-packet, then lowest valid port from 0 wins.
    clear_logs();
    push_pkt(2, 4, 32'h200);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      if (src_q[2].size() == 2) ok = 1'b1;
    end
    check("t6_reach_mid", ok, 1);
    do_reset();
    push_pkt(3, 2, 32'h330);
    push_pkt(1, 2, 32'h310);
    wait_drain("t6_drain");
    tids = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    check_tids("t6_tid", 4, tids);

    check("final_exp_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
